// File: rtl/clock_12h_alarm_if.sv
// clock_12h_alarm_if: alarm-time set handshake between a user front end and the alarm controller
// Signals: set_valid/set_hh/set_mm/set_pm (request, BCD time, meridiem) and set_ack/set_err (one-cycle response pulses)
// Modports: master drives the request and receives the response; slave is the alarm controller side
interface clock_12h_alarm_if;
  logic       set_valid;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic       set_pm;
  logic       set_ack;
  logic       set_err;
  modport master (output set_valid, set_hh, set_mm, set_pm, input set_ack, set_err);
  modport slave  (input set_valid, set_hh, set_mm, set_pm, output set_ack, set_err);
endinterface

// File: rtl/clock_12h_alarm.sv
// clock_12h_alarm: alarm controller for the 12-hour BCD clock with ring, snooze, stop and ring timeout
// Ports: clk; reset (async, active-low); ena (one-second strobe); hh/mm/ss/pm (live BCD time);
//   arm (alarm enable level); s (set handshake, slave side); snooze/stop (button levels);
//   ring (high in RINGING); snoozing (high in SNOOZE); snooze_cnt (snoozes used in this alarm event)
module clock_12h_alarm #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic [7:0]          hh,
  input  logic [7:0]          mm,
  input  logic [7:0]          ss,
  input  logic                pm,
  input  logic                arm,
  clock_12h_alarm_if.slave    s,
  input  logic                snooze,
  input  logic                stop,
  output logic                ring,
  output logic                snoozing,
  output logic [1:0]          snooze_cnt
);
  localparam int MAXS = RING_SECS > SNOOZE_SECS ? RING_SECS : SNOOZE_SECS;
  localparam int CW   = MAXS > 1 ? $clog2(MAXS) : 1;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
  state_t        state, state_n;
  logic [CW-1:0] sec_cnt, sec_n;
  logic [1:0]    snz_n;
  logic [7:0]    al_hh, al_mm;
  logic          al_pm, ack_q, err_q, set_ok, match;
  // Hours 01..09 or 10..12 in BCD; minutes tens 0..5, ones 0..9
  assign set_ok = ((s.set_hh >= 8'h01 && s.set_hh <= 8'h09) || (s.set_hh >= 8'h10 && s.set_hh <= 8'h12)) &&
                  s.set_mm[7:4] <= 4'd5 && s.set_mm[3:0] <= 4'd9;
  // Seconds==00 holds for one ena period, so this fires at most once per minute
  assign match = ena && hh == al_hh && mm == al_mm && pm == al_pm && ss == 8'h00;
  assign s.set_ack = ack_q;
  assign s.set_err = err_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      sec_cnt    <= '0;
      snooze_cnt <= '0;
      al_hh      <= 8'h12;
      al_mm      <= 8'h00;
      al_pm      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      sec_cnt    <= sec_n;
      snooze_cnt <= snz_n;
      ack_q      <= s.set_valid && set_ok;
      err_q      <= s.set_valid && !set_ok;
      if (s.set_valid && set_ok) {al_hh, al_mm, al_pm} <= {s.set_hh, s.set_mm, s.set_pm};
    end
  // Priority: set_valid > ~arm > stop > snooze > ena counting; every path into IDLE clears both counters
  always_comb begin
    state_n = state;
    sec_n   = sec_cnt;
    snz_n   = snooze_cnt;
    if (s.set_valid || !arm) begin
      state_n = IDLE;
      sec_n   = '0;
      snz_n   = '0;
    end else
      case (state)
        IDLE:
          if (match) begin
            state_n = RINGING;
            sec_n   = '0;
            snz_n   = '0;
          end
        RINGING:
          if (stop) begin
            state_n = IDLE;
            sec_n   = '0;
            snz_n   = '0;
          end else if (snooze && snooze_cnt < 2'(MAX_SNOOZE)) begin
            state_n = SNOOZE;
            sec_n   = '0;
            snz_n   = snooze_cnt + 2'd1;
          end else if (ena) begin
            state_n = sec_cnt == CW'(RING_SECS - 1) ? IDLE : RINGING;
            sec_n   = sec_cnt == CW'(RING_SECS - 1) ? '0 : sec_cnt + 1'b1;
            snz_n   = sec_cnt == CW'(RING_SECS - 1) ? 2'd0 : snooze_cnt;
          end
        SNOOZE:
          if (stop) begin
            state_n = IDLE;
            sec_n   = '0;
            snz_n   = '0;
          end else if (ena) begin
            state_n = sec_cnt == CW'(SNOOZE_SECS - 1) ? RINGING : SNOOZE;
            sec_n   = sec_cnt == CW'(SNOOZE_SECS - 1) ? '0 : sec_cnt + 1'b1;
          end
        default: begin
          state_n = IDLE;
          sec_n   = '0;
          snz_n   = '0;
        end
      endcase
  end
  always_comb begin
    ring     = state == RINGING;
    snoozing = state == SNOOZE;
  end
endmodule

// File: tb/tb_clock_12h_alarm.sv
// tb_clock_12h_alarm: self-checking bench for clock_12h_alarm (set table + scoreboard, ring/snooze/stop/reset sequences)
module tb_clock_12h_alarm;
  logic       clk, reset, ena, pm, arm, snooze, stop, ring, snoozing;
  logic [7:0] hh, mm, ss;
  logic [1:0] snooze_cnt;
  int         checks = 0;
  int         errors = 0;
  clock_12h_alarm_if sif();
  clock_12h_alarm dut (
    .clk(clk), .reset(reset), .ena(ena), .hh(hh), .mm(mm), .ss(ss), .pm(pm), .arm(arm),
    .s(sif), .snooze(snooze), .stop(stop), .ring(ring), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
  );
  typedef struct {logic ack; logic err;} sb_t;
  typedef struct {logic [7:0] h; logic [7:0] m; logic p; logic ok;} vec_t;
  sb_t  q[$];
  vec_t tbl[8];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Response monitor: every ack/err pulse must match the next queued expectation
  always @(negedge clk)
    if (reset && (sif.set_ack || sif.set_err)) begin
      if (q.size() == 0) chk("set_spurious", {sif.set_ack, sif.set_err}, 2'b00);
      else begin
        sb_t e;
        e = q.pop_front();
        chk("set_resp", {sif.set_ack, sif.set_err}, {e.ack, e.err});
      end
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic tm(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
    hh = h; mm = m; ss = s; pm = p;
  endtask
  task automatic sec(input int n);
    for (int i = 0; i < n; i++) begin
      ena = 1'b1;
      tick;
      ena = 1'b0;
      tick;
    end
  endtask
  task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic p, input logic ok);
    sif.set_valid = 1'b1;
    sif.set_hh = h;
    sif.set_mm = m;
    sif.set_pm = p;
    q.push_back('{ok, !ok});
    tick;
    sif.set_valid = 1'b0;
    tick;
  endtask
  task automatic ring_now;
    tm(8'h07, 8'h30, 8'h00, 1'b0);
    sec(1);
    tm(8'h07, 8'h30, 8'h05, 1'b0);
  endtask
  task automatic press_snooze;
    snooze = 1'b1;
    tick;
    snooze = 1'b0;
  endtask
  task automatic press_stop;
    stop = 1'b1;
    tick;
    stop = 1'b0;
  endtask
  initial begin
    reset = 1'b0; ena = 1'b0; arm = 1'b1; snooze = 1'b0; stop = 1'b0;
    sif.set_valid = 1'b0; sif.set_hh = 8'h00; sif.set_mm = 8'h00; sif.set_pm = 1'b0;
    tm(8'h12, 8'h00, 8'h01, 1'b0);
    repeat (3) tick;
    chk("rst_ring", ring, 0);
    chk("rst_snoozing", snoozing, 0);
    chk("rst_snooze_cnt", snooze_cnt, 0);
    chk("rst_ack", sif.set_ack, 0);
    chk("rst_err", sif.set_err, 0);
    reset = 1'b1;
    tick;
    tbl = '{'{8'h12, 8'h59, 1'b1, 1'b1}, '{8'h00, 8'h00, 1'b0, 1'b0}, '{8'h1A, 8'h00, 1'b0, 1'b0},
            '{8'h10, 8'h60, 1'b0, 1'b0}, '{8'h01, 8'h00, 1'b1, 1'b1}, '{8'h07, 8'h30, 1'b0, 1'b1},
            '{8'h13, 8'h00, 1'b0, 1'b0}, '{8'h05, 8'h6A, 1'b0, 1'b0}};
    for (int i = 0; i < 8; i++) do_set(tbl[i].h, tbl[i].m, tbl[i].p, tbl[i].ok);
    chk("sb_drain_table", q.size(), 0);
    // Alarm must still be 07:30 AM after the two rejected requests
    tm(8'h07, 8'h29, 8'h59, 1'b0);
    sec(1);
    chk("no_early_ring", ring, 0);
    tm(8'h07, 8'h30, 8'h00, 1'b0);
    ena = 1'b1;
    #1;
    chk("ring_before_edge", ring, 0);
    tick;
    chk("ring_rise", ring, 1);
    ena = 1'b0;
    tick;
    tm(8'h07, 8'h30, 8'h01, 1'b0);
    sec(59);
    chk("ring_59", ring, 1);
    sec(1);
    chk("ring_timeout", ring, 0);
    chk("timeout_snoozing", snoozing, 0);
    // Snooze three times, each re-ringing after 300 seconds
    ring_now;
    chk("ring_again", ring, 1);
    for (int k = 1; k <= 3; k++) begin
      press_snooze;
      chk("snoozing", snoozing, 1);
      chk("snooze_ring", ring, 0);
      chk("snooze_cnt", snooze_cnt, k);
      if (k == 1) begin
        press_snooze;
        chk("snooze_in_snooze_cnt", snooze_cnt, 1);
      end
      sec(299);
      chk("snooze_299", snoozing, 1);
      sec(1);
      chk("snooze_rering", ring, 1);
      chk("snooze_cnt_hold", snooze_cnt, k);
    end
    press_snooze;
    chk("snooze_max_ring", ring, 1);
    chk("snooze_max_cnt", snooze_cnt, 3);
    press_stop;
    chk("stop_ring", ring, 0);
    chk("stop_cnt", snooze_cnt, 0);
    // PM mismatch and disarmed alarm
    tm(8'h07, 8'h30, 8'h00, 1'b1);
    sec(1);
    chk("pm_no_ring", ring, 0);
    arm = 1'b0;
    tm(8'h07, 8'h30, 8'h00, 1'b0);
    sec(1);
    chk("disarm_no_ring", ring, 0);
    arm = 1'b1;
    ring_now;
    chk("rearm_ring", ring, 1);
    arm = 1'b0;
    tick;
    chk("arm_drop_ring", ring, 0);
    arm = 1'b1;
    // Asynchronous reset mid-ring, then alarm back to 12:00 AM
    ring_now;
    chk("pre_reset_ring", ring, 1);
    #2 reset = 1'b0;
    #1 chk("async_rst_ring", ring, 0);
    tick;
    reset = 1'b1;
    tick;
    tm(8'h07, 8'h30, 8'h00, 1'b0);
    sec(1);
    chk("rst_alarm_not_0730", ring, 0);
    tm(8'h12, 8'h00, 8'h00, 1'b0);
    sec(1);
    chk("rst_alarm_1200am", ring, 1);
    press_stop;
    // Asynchronous reset mid-snooze
    do_set(8'h07, 8'h30, 1'b0, 1'b1);
    ring_now;
    press_snooze;
    chk("pre_reset_snoozing", snoozing, 1);
    #2 reset = 1'b0;
    #1 chk("async_rst_snoozing", snoozing, 0);
    chk("async_rst_cnt", snooze_cnt, 0);
    tick;
    reset = 1'b1;
    tick;
    chk("sb_drain_end", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
